arb_client: RTL and testbench

- Requester-side agent for the 3-way fixed-priority grant arbiter.
- Converts a one-cycle job command (`start` + `len`) into a request level on one arbiter request line.
- Holds the request for exactly `len` granted cycles, then releases it.
- Does not re-request until the arbiter's registered grant is confirmed low.
- One instance per arbiter requester line (r[0..2]).

---
 rtl/arb_pkg.sv | 26 ++
 rtl/sat_counter.sv | 37 +++
 rtl/arb_client.sv | 185 ++++++++++++++++++
 tb/tb_arb_client.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 3-way fixed-priority arbiter and its requester clients.
package arb_pkg;

  // Client protocol states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OWN  = 2'd2,
    REL  = 2'd3
  } arb_state_e;

  localparam int NUM_CLIENTS = 3;
  // The arbiter registers its state and then its grant, so a released grant
  // is only trustworthy after two low samples.
  localparam int REL_MIN     = 2;

  localparam int CLIENT0 = 0;
  localparam int CLIENT1 = 1;
  localparam int CLIENT2 = 2;

  // True in the states where the client drives its request line high.
  function automatic logic state_requests(arb_state_e s);
    return (s == REQ) || (s == OWN);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that parks at LIMIT instead of wrapping; clear has priority over enable.
module sat_counter #(
  parameter int             W     = 8,
  parameter logic [W-1:0]   LIMIT = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: clear wins, otherwise step up until LIMIT is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/arb_client.sv
// Requester-side agent for the 3-way fixed-priority arbiter.
// Turns a one-cycle job command (start + len) into a request level held for
// exactly len granted cycles, abandons the job after TIMEOUT ungranted cycles,
// and only returns to IDLE once the registered grant has been seen low for
// REL_CYCLES consecutive cycles.
// Optional build macro ARB_CLIENT_STATS_EN adds the last_wait statistics port.
module arb_client
  import arb_pkg::*;
#(
  parameter int LEN_W      = 8,
  parameter int TIMEOUT    = 16,
  parameter int REL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             gnt,
  output logic             req,
  output logic             busy,
  output logic             active,
  output logic             done,
  output logic             timeout_err
`ifdef ARB_CLIENT_STATS_EN
  ,
  output logic [7:0]       last_wait
`endif
);

  localparam int               CNT_W     = 8;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REL_SAT   = CNT_W'(REL_CYCLES);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_CYCLES - 1);
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

  arb_state_e       state_d, state_q;
  logic             req_d, req_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             terr_d, terr_q;
  logic             abandon_d, abandon_q;
  logic [LEN_W-1:0] len_d, len_q;
  logic [LEN_W-1:0] beat_d, beat_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] rel_cnt;

  // Ungranted cycles in REQ; held at zero outside REQ so each entry starts fresh.
  sat_counter #(.W(CNT_W), .LIMIT(WAIT_LAST)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q != REQ),
    .en    (1'b1),
    .cnt   (wait_cnt)
  );

  // Consecutive gnt-low cycles in REL; any grant seen in REL restarts the run,
  // which covers a grant that arrives just after an abandoned request fell.
  sat_counter #(.W(CNT_W), .LIMIT(REL_SAT)) u_rel_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_q != REL) || gnt),
    .en    (1'b1),
    .cnt   (rel_cnt)
  );

  // Next-state and registered-output decode for the job FSM.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beat_d    = beat_q;
    abandon_d = abandon_q;
    done_d    = 1'b0;
    terr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = REQ;
            len_d     = len;
            beat_d    = '0;
            abandon_d = 1'b0;
          end
        end
      end
      REQ: begin
        if (gnt) begin
          beat_d  = ONE;
          state_d = (len_q == ONE) ? REL : OWN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_d   = REL;
          abandon_d = 1'b1;
        end
      end
      OWN: begin
        // A missing grant here is an arbiter protocol error: keep requesting
        // and simply do not count the cycle.
        if (gnt) begin
          beat_d = beat_q + ONE;
          if ((beat_q + ONE) == len_q) begin
            state_d = REL;
          end
        end
      end
      REL: begin
        if (!gnt && (rel_cnt == REL_LAST)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          terr_d  = abandon_q;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d  = state_requests(state_d);
    busy_d = (state_d != IDLE);
  end

  // Control registers; reset drops req immediately and suppresses done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      terr_q    <= 1'b0;
      abandon_q <= 1'b0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      terr_q    <= terr_d;
      abandon_q <= abandon_d;
      beat_q    <= beat_d;
    end
  end

  // Job length is plain data captured with start; it needs no reset.
  always_ff @(posedge clk) begin
    len_q <= len_d;
  end

  assign req         = req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign active      = gnt & req_q & state_requests(state_q);

`ifdef ARB_CLIENT_STATS_EN
  logic [7:0] req_cyc;
  logic [7:0] last_wait_d;
  logic [7:0] last_wait_q;

  // REQ-state cycles of the current job; zero while idle, frozen through REL.
  sat_counter #(.W(8), .LIMIT(8'd255)) u_req_cyc (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == IDLE),
    .en    (state_q == REQ),
    .cnt   (req_cyc)
  );

  // Capture the wait figure whenever a job finishes or is abandoned.
  always_comb begin
    last_wait_d = last_wait_q;
    if (done_d) begin
      last_wait_d = req_cyc;
    end
  end

  // Statistics register.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_wait_q <= '0;
    end else begin
      last_wait_q <= last_wait_d;
    end
  end

  assign last_wait = last_wait_q;
`endif

endmodule

// File: tb/tb_arb_client.sv
// Bench for arb_client: three clients on a behavioural fixed-priority arbiter,
// directed job scenarios plus randomized traffic against a job-level model.
module tb_arb_client;

  localparam int N          = 3;
  localparam int TIMEOUT    = 16;
  localparam int REL_CYCLES = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] start;
  logic [7:0]   len_i [N];
  logic [N-1:0] gnt_vec = '0;
  logic         req_o  [N];
  logic         busy_o [N];
  logic         act_o  [N];
  logic         done_o [N];
  logic         terr_o [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_cli
`ifdef ARB_CLIENT_STATS_EN
    logic [7:0] last_wait;
`endif
    arb_client #(.LEN_W(8), .TIMEOUT(TIMEOUT), .REL_CYCLES(REL_CYCLES)) u_dut (
      .clk         (clk),
      .reset       (rst),
      .start       (start[g]),
      .len         (len_i[g]),
      .gnt         (gnt_vec[g]),
      .req         (req_o[g]),
      .busy        (busy_o[g]),
      .active      (act_o[g]),
      .done        (done_o[g]),
      .timeout_err (terr_o[g])
`ifdef ARB_CLIENT_STATS_EN
      ,
      .last_wait   (last_wait)
`endif
    );
  end

  // Arbiter environment: non-preemptive fixed priority (r0 highest), with the
  // owner registered from req and the grant registered from the owner.
  int owner = -1;
  int arb_nxt;

  always_comb begin
    arb_nxt = -1;
    for (int k = N - 1; k >= 0; k--) if (req_o[k]) arb_nxt = k;
    for (int k = 0; k < N; k++) if ((owner == k) && req_o[k]) arb_nxt = k;
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) gnt_vec[k] <= (owner == k);
    owner <= arb_nxt;
  end

  // Checking.
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Job-level reference: each client is idle, requesting (with a count of
  // beats received and ungranted cycles waited) or releasing (with a run of
  // grant-low cycles).
  bit m_busy [N];
  bit m_req  [N];
  bit m_done [N];
  bit m_terr [N];
  bit m_aband[N];
  int m_len  [N];
  int m_got  [N];
  int m_wait [N];
  int m_low  [N];

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_busy[i] = 0; m_req[i] = 0; m_done[i] = 0; m_terr[i] = 0;
        continue;
      end
      m_done[i] = 0;
      m_terr[i] = 0;
      if (!m_busy[i]) begin
        if (start[i]) begin
          if (len_i[i] == 0) m_done[i] = 1;
          else begin
            m_busy[i] = 1; m_req[i] = 1; m_len[i] = int'(len_i[i]);
            m_got[i] = 0; m_wait[i] = 0; m_aband[i] = 0;
          end
        end
      end else if (m_req[i]) begin
        if (gnt_vec[i]) begin
          m_got[i]++;
          if (m_got[i] == m_len[i]) begin m_req[i] = 0; m_low[i] = 0; end
        end else if (m_got[i] == 0) begin
          m_wait[i]++;
          if (m_wait[i] == TIMEOUT) begin m_req[i] = 0; m_aband[i] = 1; m_low[i] = 0; end
        end
      end else begin
        m_low[i] = gnt_vec[i] ? 0 : m_low[i] + 1;
        if (m_low[i] == REL_CYCLES) begin
          m_busy[i] = 0; m_done[i] = 1; m_terr[i] = m_aband[i];
        end
      end
    end
  endtask

  task automatic compare();
    int nact;
    nact = 0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("c%0d_req", i),    int'(req_o[i]),  int'(m_req[i]));
      chk($sformatf("c%0d_busy", i),   int'(busy_o[i]), int'(m_busy[i]));
      chk($sformatf("c%0d_done", i),   int'(done_o[i]), int'(m_done[i]));
      chk($sformatf("c%0d_terr", i),   int'(terr_o[i]), int'(m_terr[i]));
      chk($sformatf("c%0d_active", i), int'(act_o[i]),  int'(m_req[i] & gnt_vec[i]));
      nact += int'(act_o[i]);
    end
    chk("one_active", int'(nact <= 1), 1);
  endtask

  // Per-window event record, indexed by cycle t after the start command.
  int t;
  int s_first_req[N], s_req_fall[N], s_rerise[N], s_first_gnt[N];
  int s_act[N], s_done[N], s_done_t[N], s_terr[N], s_terr_t[N], s_busy_ever[N];

  task automatic clear_stats();
    t = 0;
    for (int i = 0; i < N; i++) begin
      s_first_req[i] = -1; s_req_fall[i] = -1; s_rerise[i] = -1; s_first_gnt[i] = -1;
      s_act[i] = 0; s_done[i] = 0; s_done_t[i] = -1; s_terr[i] = 0; s_terr_t[i] = -1;
      s_busy_ever[i] = 0;
    end
  endtask

  task automatic record();
    for (int i = 0; i < N; i++) begin
      if (req_o[i]) begin
        if (s_first_req[i] < 0) s_first_req[i] = t;
        else if ((s_req_fall[i] >= 0) && (s_rerise[i] < 0)) s_rerise[i] = t;
      end else if ((s_first_req[i] >= 0) && (s_req_fall[i] < 0)) begin
        s_req_fall[i] = t;
      end
      if (gnt_vec[i] && (s_first_gnt[i] < 0)) s_first_gnt[i] = t;
      if (act_o[i]) s_act[i]++;
      if (busy_o[i]) s_busy_ever[i] = 1;
      if (done_o[i]) begin s_done[i]++; if (s_done_t[i] < 0) s_done_t[i] = t; end
      if (terr_o[i]) begin s_terr[i]++; if (s_terr_t[i] < 0) s_terr_t[i] = t; end
    end
  endtask

  // One clock: the model consumes this cycle's inputs, then outputs of the
  // next cycle are checked half a period after the edge.
  task automatic tick();
    model_step();
    @(negedge clk);
    t++;
    compare();
    record();
  endtask

  task automatic go(input int i, input int l);
    start[i] = 1'b1;
    len_i[i] = 8'(l);
  endtask

  task automatic idle();
    start = '0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst   = 1'b1;
    start = '0;
    for (int i = 0; i < N; i++) len_i[i] = 8'd0;
    @(negedge clk);
    compare();
    tick();
    rst = 1'b0;
    run(3);

    // Lone client, idle arbiter, len=3.
    clear_stats(); go(0, 3); tick(); idle(); run(13);
    chk("l3_req_rise",  s_first_req[0], 1);
    chk("l3_gnt_rise",  s_first_gnt[0], 3);
    chk("l3_active",    s_act[0],       3);
    chk("l3_req_fall",  s_req_fall[0],  6);
    chk("l3_done_t",    s_done_t[0],    10);
    chk("l3_done_cnt",  s_done[0],      1);
    chk("l3_terr_cnt",  s_terr[0],      0);

    // Zero-length job.
    clear_stats(); go(1, 0); tick(); idle(); run(4);
    chk("l0_done_t",    s_done_t[1],    1);
    chk("l0_done_cnt",  s_done[1],      1);
    chk("l0_req_rise",  s_first_req[1], -1);
    chk("l0_busy",      s_busy_ever[1], 0);

    // r2 starved by a 20-beat job on r0: abandoned after TIMEOUT REQ cycles.
    clear_stats(); go(0, 20); go(2, 4); tick(); idle(); run(35);
    chk("to_req_rise",  s_first_req[2], 1);
    chk("to_req_fall",  s_req_fall[2],  17);
    chk("to_active",    s_act[2],       0);
    chk("to_gnt",       s_first_gnt[2], -1);
    chk("to_done_t",    s_done_t[2],    19);
    chk("to_terr_t",    s_terr_t[2],    s_done_t[2]);
    chk("to_terr_cnt",  s_terr[2],      1);
    chk("to_hog_act",   s_act[0],       20);
    chk("to_hog_done",  s_done[0],      1);

    // Timeout race: r0 releases just as r2 gives up, so r2's grant rises
    // one cycle after its request fell. Starts during REL must be ignored.
    clear_stats(); go(0, 13); go(2, 2); tick(); idle();
    while (t < 35) begin
      if ((t >= 18) && (t <= 21)) go(2, (t == 21) ? 2 : 5);
      tick(); idle();
    end
    chk("race_req_fall", s_req_fall[2],  17);
    chk("race_gnt",      s_first_gnt[2], 18);
    chk("race_done_t",   s_done_t[2],    21);
    chk("race_terr_t",   s_terr_t[2],    21);
    chk("race_terr_cnt", s_terr[2],      1);
    chk("race_rerise",   s_rerise[2],    22);
    chk("race_active",   s_act[2],       2);
    chk("race_done_cnt", s_done[2],      2);
    chk("race_r0_act",   s_act[0],       13);
    chk("race_r0_done",  s_done_t[0],    20);

    // Three simultaneous jobs serialise by priority.
    clear_stats(); go(0, 2); go(1, 4); go(2, 1); tick(); idle(); run(29);
    chk("tri_gnt0", s_first_gnt[0], 3);
    chk("tri_gnt1", s_first_gnt[1], 7);
    chk("tri_gnt2", s_first_gnt[2], 13);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("tri_done%0d", i), s_done[i], 1);
      chk($sformatf("tri_terr%0d", i), s_terr[i], 0);
    end
    chk("tri_act0", s_act[0], 2);
    chk("tri_act1", s_act[1], 4);
    chk("tri_act2", s_act[2], 1);

    // Reset on beat 2 of 5, then a fresh job.
    clear_stats(); go(0, 5); tick(); idle();
    while (t < 10) begin
      rst = (t == 4);
      tick();
    end
    rst = 1'b0;
    chk("rst_req_fall", s_req_fall[0], 5);
    chk("rst_done_cnt", s_done[0],     0);
    chk("rst_active",   s_act[0],      2);
    clear_stats(); go(0, 2); tick(); idle(); run(12);
    chk("post_req_rise", s_first_req[0], 1);
    chk("post_gnt",      s_first_gnt[0], 3);
    chk("post_active",   s_act[0],       2);
    chk("post_done_t",   s_done_t[0],    9);
    chk("post_done_cnt", s_done[0],      1);

    // Randomized traffic, including starts while busy and rare resets.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) go(i, int'($urandom_range(0, 6)));
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
      idle();
      rst = 1'b0;
    end
    run(60);
    for (int i = 0; i < N; i++) chk($sformatf("drain_busy%0d", i), int'(busy_o[i]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
